// File: rtl/ro_freq_counter.sv
// Gated frequency counter for a ring oscillator: enable, settle, then count
// synchronized oscillator rising edges over a fixed window of clk cycles.
module ro_freq_counter #(
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned GATE_CYCLES   = 1024,
  parameter int unsigned SETTLE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             ro_in,
  output logic             ro_activate,
  output logic             busy,
  output logic             done,
  output logic             valid,
  output logic             overflow,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned TICK_W      = 20;
  localparam logic [TICK_W-1:0] SETTLE_LAST = TICK_W'(SETTLE_CYCLES - 1);
  localparam logic [TICK_W-1:0] GATE_LAST   = TICK_W'(GATE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    MEASURE,
    DONE
  } state_e;

  state_e             state_q;
  logic               s1_q, s2_q, s3_q;
  logic               rise;
  logic [TICK_W-1:0]  tick_q;
  logic [CNT_W-1:0]   edge_q, edge_d;
  logic               ovf_q, ovf_d;
  logic               act_q, busy_q, done_q, valid_q, overflow_q;
  logic [CNT_W-1:0]   count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= ro_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise = s2_q & ~s3_q;

  // Saturating edge count including the rise seen on this edge, so the
  // closing edge of the window contributes to the latched result.
  always_comb begin
    edge_d = edge_q;
    ovf_d  = ovf_q;
    if (rise) begin
      if (edge_q == '1) begin
        ovf_d = 1'b1;
      end else begin
        edge_d = edge_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tick_q     <= '0;
      edge_q     <= '0;
      ovf_q      <= 1'b0;
      act_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
      count_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q    <= SETTLE;
            tick_q     <= '0;
            edge_q     <= '0;
            ovf_q      <= 1'b0;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
            act_q      <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        SETTLE: begin
          if (abort) begin
            state_q <= IDLE;
            act_q   <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
          end else if (tick_q == SETTLE_LAST) begin
            state_q <= MEASURE;
            tick_q  <= '0;
          end else begin
            tick_q <= tick_q + 1'b1;
          end
        end
        MEASURE: begin
          if (abort) begin
            state_q <= IDLE;
            act_q   <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
          end else begin
            edge_q <= edge_d;
            ovf_q  <= ovf_d;
            if (tick_q == GATE_LAST) begin
              state_q    <= DONE;
              count_q    <= edge_d;
              overflow_q <= ovf_d;
              valid_q    <= 1'b1;
              done_q     <= 1'b1;
              act_q      <= 1'b0;
              busy_q     <= 1'b0;
            end else begin
              tick_q <= tick_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          act_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ro_activate = act_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign valid       = valid_q;
  assign overflow    = overflow_q;
  assign count       = count_q;

endmodule

// File: tb/tb_ro_freq_counter.sv
// Bench for ro_freq_counter: two instances (16-bit and 4-bit counters) share
// stimulus; expected counts come from the recorded sampled ro_in history.
module tb_ro_freq_counter;

  localparam int S = 4;
  localparam int G = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic ro_in = 1'b0;

  logic        act_a, busy_a, done_a, valid_a, ovf_a;
  logic [15:0] count_a;
  logic        act_b, busy_b, done_b, valid_b, ovf_b;
  logic [3:0]  count_b;

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;
  bit samp [0:65535];

  int ro_mode = 0;
  bit ro_lvl  = 1'b0;
  int half    = 4;
  int ph      = 0;

  ro_freq_counter #(.CNT_W(16), .GATE_CYCLES(G), .SETTLE_CYCLES(S)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .ro_in(ro_in),
    .ro_activate(act_a), .busy(busy_a), .done(done_a), .valid(valid_a),
    .overflow(ovf_a), .count(count_a)
  );

  ro_freq_counter #(.CNT_W(4), .GATE_CYCLES(G), .SETTLE_CYCLES(S)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .ro_in(ro_in),
    .ro_activate(act_b), .busy(busy_b), .done(done_b), .valid(valid_b),
    .overflow(ovf_b), .count(count_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    samp[cyc] = ro_in;
    cyc = cyc + 1;
  end

  // Oscillator model: constant, periodic (toggle every `half` cycles) or random level.
  always @(negedge clk) begin
    if (ro_mode == 0) begin
      ro_in = ro_lvl;
    end else if (ro_mode == 1) begin
      ph = ph + 1;
      if (ph >= half) begin
        ph = 0;
        ro_in = ~ro_in;
      end
    end else begin
      #($urandom_range(0, 4));
      ro_in = 1'($urandom_range(0, 1));
    end
  end

  // A rising edge counts at edge n when ro_in sampled at n-2 is 1 and at n-3 is 0.
  function automatic int true_rises(input int t0);
    int c;
    c = 0;
    for (int n = t0 + S + 1; n <= t0 + S + G; n++)
      if (samp[n-2] == 1'b1 && samp[n-3] == 1'b0) c++;
    return c;
  endfunction

  task automatic do_start(output int t0);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc - 1;
    start = 1'b0;
  endtask

  task automatic finish_check(input int t0, input string nm, input bit hold, output int tr);
    int de, e16, e4;
    bit eo16, eo4;
    de = -1;
    tr = -1;
    for (int i = 0; i < S + G + 20; i++) begin
      @(posedge clk);
      #1;
      if (done_a === 1'b1) begin
        de = cyc - 1;
        break;
      end
    end
    nchk++;
    if (de != t0 + S + G) begin
      nerr++;
      $display("FAIL %s done_edge got %0d expected %0d", nm, de, t0 + S + G);
    end
    if (de < 0) return;
    tr   = true_rises(t0);
    e16  = (tr > 65535) ? 65535 : tr;
    eo16 = (tr > 65535);
    e4   = (tr > 15) ? 15 : tr;
    eo4  = (tr > 15);
    nchk++;
    if (count_a !== 16'(e16) || ovf_a !== eo16) begin
      nerr++;
      $display("FAIL %s count16 got %0d/ovf %b expected %0d/ovf %b", nm, count_a, ovf_a, e16, eo16);
    end
    nchk++;
    if (count_b !== 4'(e4) || ovf_b !== eo4) begin
      nerr++;
      $display("FAIL %s count4 got %0d/ovf %b expected %0d/ovf %b", nm, count_b, ovf_b, e4, eo4);
    end
    nchk++;
    if ({valid_a, valid_b, done_b, act_a, busy_a, act_b, busy_b} !== 7'b1110000) begin
      nerr++;
      $display("FAIL %s done_flags got %b expected 1110000", nm,
               {valid_a, valid_b, done_b, act_a, busy_a, act_b, busy_b});
    end
    if (hold) begin
      @(posedge clk);
      #1;
      nchk++;
      if (done_a !== 1'b0 || valid_a !== 1'b1 || count_a !== 16'(e16)) begin
        nerr++;
        $display("FAIL %s hold got done %b valid %b count %0d expected 0 1 %0d",
                 nm, done_a, valid_a, count_a, e16);
      end
    end
  endtask

  task automatic test_reset;
    ro_mode = 2;
    #1 rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      nchk++;
      if ({act_a, busy_a, done_a, valid_a, ovf_a, act_b, busy_b, done_b, valid_b, ovf_b} !== 10'b0
          || count_a !== 16'd0 || count_b !== 4'd0) begin
        nerr++;
        $display("FAIL reset_outputs cycle %0d got act %b busy %b done %b valid %b count %0d expected all 0",
                 i, act_a, busy_a, done_a, valid_a, count_a);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      nchk++;
      if (act_a !== 1'b0 || busy_a !== 1'b0) begin
        nerr++;
        $display("FAIL idle_no_start got act %b busy %b expected 0 0", act_a, busy_a);
      end
    end
  endtask

  task automatic test_nominal;
    int t0, tr;
    ro_mode = 1; half = 4; ph = 0;
    repeat (12) @(posedge clk);
    do_start(t0);
    nchk++;
    if (act_a !== 1'b1 || busy_a !== 1'b1) begin
      nerr++;
      $display("FAIL start_activate got act %b busy %b expected 1 1", act_a, busy_a);
    end
    finish_check(t0, "nominal", 1'b1, tr);
    nchk++;
    if (count_a !== 16'd8 || ovf_a !== 1'b0) begin
      nerr++;
      $display("FAIL nominal_const got count %0d ovf %b expected 8 0", count_a, ovf_a);
    end
  endtask

  task automatic test_static;
    int t0, tr;
    for (int lv = 0; lv < 2; lv++) begin
      ro_mode = 0; ro_lvl = 1'(lv);
      repeat (6) @(posedge clk);
      do_start(t0);
      finish_check(t0, "static", 1'b1, tr);
      nchk++;
      if (count_a !== 16'd0 || valid_a !== 1'b1) begin
        nerr++;
        $display("FAIL static_level%0d got count %0d valid %b expected 0 1", lv, count_a, valid_a);
      end
    end
  endtask

  task automatic test_saturation;
    int t0, tr;
    ro_mode = 1; half = 1; ph = 0;
    repeat (6) @(posedge clk);
    do_start(t0);
    finish_check(t0, "saturate", 1'b1, tr);
    nchk++;
    if (count_b !== 4'd15 || ovf_b !== 1'b1 || count_a !== 16'd32 || ovf_a !== 1'b0) begin
      nerr++;
      $display("FAIL saturate_const got c4 %0d o4 %b c16 %0d o16 %b expected 15 1 32 0",
               count_b, ovf_b, count_a, ovf_a);
    end
  endtask

  task automatic test_random;
    int t0, tr;
    for (int r = 0; r < 6; r++) begin
      if ($urandom_range(0, 1) == 0) begin
        ro_mode = 1; half = $urandom_range(1, 12); ph = 0;
      end else begin
        ro_mode = 2;
      end
      repeat ($urandom_range(3, 10)) @(posedge clk);
      do_start(t0);
      finish_check(t0, "random", 1'b1, tr);
    end
  endtask

  task automatic test_ignored_start_abort;
    int t0, tr, seen;
    logic [15:0] pa;
    logic [3:0]  pb;
    ro_mode = 2;
    do_start(t0);
    repeat (S + 10) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    nchk++;
    if (busy_a !== 1'b1 || act_a !== 1'b1) begin
      nerr++;
      $display("FAIL start_in_measure got busy %b act %b expected 1 1", busy_a, act_a);
    end
    finish_check(t0, "ignored_start", 1'b1, tr);
    pa = count_a; pb = count_b;
    do_start(t0);
    repeat (S + 5) @(posedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    nchk++;
    if ({busy_a, act_a, valid_a, done_a, busy_b, act_b, valid_b} !== 7'b0 ||
        count_a !== pa || count_b !== pb) begin
      nerr++;
      $display("FAIL abort_measure got busy %b act %b valid %b done %b count %0d expected 0 0 0 0 %0d",
               busy_a, act_a, valid_a, done_a, count_a, pa);
    end
    seen = 0;
    for (int i = 0; i < G + 10; i++) begin
      @(posedge clk);
      #1;
      if (done_a !== 1'b0 || busy_a !== 1'b0) seen++;
    end
    nchk++;
    if (seen != 0) begin
      nerr++;
      $display("FAIL abort_no_done got %0d active cycles expected 0", seen);
    end
    do_start(t0);
    @(posedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    nchk++;
    if (busy_a !== 1'b0 || act_a !== 1'b0) begin
      nerr++;
      $display("FAIL abort_settle got busy %b act %b expected 0 0", busy_a, act_a);
    end
    repeat (3) @(posedge clk);
    do_start(t0);
    finish_check(t0, "restart", 1'b1, tr);
  endtask

  task automatic test_done_controls;
    int t0, tr;
    logic [15:0] pa;
    pa = count_a;
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    nchk++;
    if (valid_a !== 1'b1 || count_a !== pa) begin
      nerr++;
      $display("FAIL abort_in_done got valid %b count %0d expected 1 %0d", valid_a, count_a, pa);
    end
    @(negedge clk);
    abort = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc - 1;
    abort = 1'b0;
    start = 1'b0;
    nchk++;
    if (busy_a !== 1'b1 || valid_a !== 1'b0) begin
      nerr++;
      $display("FAIL start_wins got busy %b valid %b expected 1 0", busy_a, valid_a);
    end
    finish_check(t0, "start_wins", 1'b0, tr);
  endtask

  task automatic test_back_to_back;
    int t0, tr;
    start = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc - 1;
    start = 1'b0;
    nchk++;
    if (valid_a !== 1'b0 || busy_a !== 1'b1 || done_a !== 1'b0) begin
      nerr++;
      $display("FAIL back_to_back got valid %b busy %b done %b expected 0 1 0", valid_a, busy_a, done_a);
    end
    finish_check(t0, "back_to_back", 1'b1, tr);
  endtask

  task automatic test_async_reset;
    int t0, tr;
    ro_mode = 1; half = 3; ph = 0;
    for (int k = 0; k < 2; k++) begin
      do_start(t0);
      repeat ((k == 0) ? 1 : S + 20) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      nchk++;
      if ({act_a, busy_a, done_a, valid_a, ovf_a, act_b, busy_b, valid_b} !== 8'b0 ||
          count_a !== 16'd0 || count_b !== 4'd0) begin
        nerr++;
        $display("FAIL async_reset_%0d got act %b busy %b valid %b count %0d expected 0 0 0 0",
                 k, act_a, busy_a, valid_a, count_a);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      do_start(t0);
      finish_check(t0, "after_reset", 1'b1, tr);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_nominal();
    test_static();
    test_saturation();
    test_random();
    test_ignored_start_abort();
    test_done_controls();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
